// File: rtl/stream_mux_n.sv
// -----------------------------------------------------------------------------
// stream_mux_n
//   N-channel, WIDTH-bit registered stream multiplexer with a valid/ready
//   handshake on every side. The channel is picked either by an external
//   select (MODE 0) or by an internal round-robin arbiter (MODE 1). The chosen
//   word goes into a single output register stage.
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high reset
//   in_data    in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   in   N          channel i offers a word
//   in_ready   out  N          channel i word is taken this cycle if in_valid[i]
//   sel        in   SELW       MODE 0 channel select, values >= N select nothing
//   out_data   out  WIDTH      registered output word
//   out_valid  out  1          out_data holds a valid word
//   out_ready  in   1          consumer accepts out_data this cycle
//   out_chan   out  SELW       channel index that out_data came from
// -----------------------------------------------------------------------------
module stream_mux_n #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    // N held one bit wider so that power-of-2 N does not truncate to 0.
    localparam logic [SELW:0] NL = (SELW+1)'(N);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SELW-1:0]  chan_q,  chan_d;

    logic             space;
    logic             grant_ok;
    logic [SELW-1:0]  grant;
    logic             load;

    // Output register is free, or is being drained by the consumer this cycle.
    assign space = !valid_q || out_ready;

    generate
        if (MODE == 0) begin : g_ext
            assign grant_ok = ({1'b0, sel} < NL);
            assign grant    = sel;
        end else begin : g_rr
            logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
            wire             unused_sel = ^sel;

            // Walk from the farthest candidate back to rr_ptr so the nearest
            // valid channel (in round-robin order) is the last one written.
            always_comb begin
                logic [SELW:0] idx;
                idx      = '0;
                grant_ok = 1'b0;
                grant    = '0;
                for (int k = N-1; k >= 0; k--) begin
                    idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
                    if (idx >= NL) idx = idx - NL;
                    if (in_valid[idx[SELW-1:0]]) begin
                        grant_ok = 1'b1;
                        grant    = idx[SELW-1:0];
                    end
                end
            end

            // Pointer moves just past the channel that was served.
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (load)
                    rr_ptr_d = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) rr_ptr_q <= '0;
                else       rr_ptr_q <= rr_ptr_d;
            end
        end
    endgenerate

    // in_ready is forced low while reset is held, even though the output
    // register is empty at that point.
    always_comb begin
        in_ready = '0;
        if (!reset && space && grant_ok) in_ready[grant] = 1'b1;
    end

    assign load = !reset && space && grant_ok && in_valid[grant];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
            chan_d  = grant;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule
